// File: rtl/ws_sequencer.sv
// ws_sequencer - front-side-bus access sequencer for the accelerator CPLD.
//
// Classifies each 68000-style bus cycle as RAM, ROM or I/O from A[23:20].
// It adds the configured wait states and passes I/O cycles to the slow-bus
// bridge over a req/ack handshake. Every cycle ends with nDTACK or nBERR.
// When enabled, I/O write starts are held a minimum distance apart.
//
// Ports:
//   FCLK      in   fast bus clock, all state changes on its rising edge
//   RST       in   asynchronous active-high reset
//   nAS       in   address strobe (active low, synchronous to FCLK)
//   nWE       in   0 = write cycle
//   A[3:0]    in   A[23:20] of the current cycle
//   RAMWS     in   RAM wait-state enable
//   ROMWS     in   ROM wait-state enable
//   IOWS      in   I/O wait-state enable
//   IOSlowEN  in   I/O write spacing enable
//   IOAck     in   bridge completion (level, held until IOReq falls)
//   IOReq     out  request to slow-bus bridge
//   IOWrite   out  write flag for the bridge, valid while IOReq=1
//   nDTACK    out  data acknowledge, active low
//   nBERR     out  bus error, active low
//   Busy      out  1 whenever the sequencer is not idle
module ws_sequencer #(
  parameter int RAM_WS = 1,
  parameter int ROM_WS = 2,
  parameter int IO_WS  = 3,
  parameter int IO_GAP = 8,
  parameter int TO_CYC = 255
) (
  input  logic       FCLK,
  input  logic       RST,
  input  logic       nAS,
  input  logic       nWE,
  input  logic [3:0] A,
  input  logic       RAMWS,
  input  logic       ROMWS,
  input  logic       IOWS,
  input  logic       IOSlowEN,
  input  logic       IOAck,
  output logic       IOReq,
  output logic       IOWrite,
  output logic       nDTACK,
  output logic       nBERR,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_GAP, S_IOREQ, S_ACK, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    C_RAM, C_ROM, C_IO
  } cls_t;

  state_t     state_q;
  cls_t       cls_q;
  logic       wr_q;        // latched write flag of the current cycle
  logic [7:0] io_ld_q;     // I/O wait count latched at decode (used after GAP)
  logic [7:0] wait_q;
  logic [7:0] gap_q;
  logic [7:0] to_q;
  logic       armed_q;     // nAS seen high since the last accepted cycle
  logic       ioreq_q;
  logic       iowrite_q;
  logic       dtack_n_q;
  logic       berr_n_q;
  logic       busy_q;

  cls_t       cls_dec;
  logic [7:0] mem_ld;
  logic [7:0] io_ld;

  // 4'h4 also has A[23]=0, so the ROM window must be matched before the
  // RAM half of the map or ROM would never be selected.
  always_comb begin
    cls_dec = C_IO;
    if (A == 4'h4)
      cls_dec = C_ROM;
    else if (!A[3])
      cls_dec = C_RAM;
  end

  always_comb begin
    mem_ld = 8'd0;
    if (cls_dec == C_ROM) begin
      if (ROMWS) mem_ld = 8'(ROM_WS);
    end else begin
      if (RAMWS) mem_ld = 8'(RAM_WS);
    end
  end

  assign io_ld = IOWS ? 8'(IO_WS) : 8'd0;

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cls_q     <= C_RAM;
      wr_q      <= 1'b0;
      io_ld_q   <= 8'd0;
      wait_q    <= 8'd0;
      gap_q     <= 8'd0;
      to_q      <= 8'd0;
      armed_q   <= 1'b0;
      ioreq_q   <= 1'b0;
      iowrite_q <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (nAS) armed_q <= 1'b1;

      // Gap counter free-runs down to 0; a write request below reloads it.
      if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;

      case (state_q)
        S_IDLE: begin
          if (!nAS && armed_q) begin
            armed_q <= 1'b0;
            cls_q   <= cls_dec;
            wr_q    <= !nWE;
            io_ld_q <= io_ld;
            busy_q  <= 1'b1;
            if (cls_dec == C_IO) begin
              if (!nWE && IOSlowEN && (gap_q != 8'd0)) begin
                state_q <= S_GAP;
              end else if (io_ld != 8'd0) begin
                state_q <= S_WAIT;
                wait_q  <= io_ld;
              end else begin
                state_q   <= S_IOREQ;
                ioreq_q   <= 1'b1;
                iowrite_q <= !nWE;
                to_q      <= 8'd0;
                if (!nWE) gap_q <= 8'(IO_GAP);
              end
            end else begin
              if (mem_ld != 8'd0) begin
                state_q <= S_WAIT;
                wait_q  <= mem_ld;
              end else begin
                state_q <= S_ACK;
              end
            end
          end
        end

        S_WAIT: begin
          if (nAS) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
            busy_q  <= 1'b0;
          end else if (wait_q == 8'd1) begin
            wait_q <= 8'd0;
            if (cls_q == C_IO) begin
              state_q   <= S_IOREQ;
              ioreq_q   <= 1'b1;
              iowrite_q <= wr_q;
              to_q      <= 8'd0;
              if (wr_q) gap_q <= 8'(IO_GAP);
            end else begin
              state_q <= S_ACK;
            end
          end else begin
            wait_q <= wait_q - 8'd1;
          end
        end

        S_GAP: begin
          if (nAS) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == 8'd0) begin
            if (io_ld_q != 8'd0) begin
              state_q <= S_WAIT;
              wait_q  <= io_ld_q;
            end else begin
              state_q   <= S_IOREQ;
              ioreq_q   <= 1'b1;
              iowrite_q <= wr_q;
              to_q      <= 8'd0;
              if (wr_q) gap_q <= 8'(IO_GAP);
            end
          end
        end

        S_IOREQ: begin
          // Abort beats a late IOAck; IOAck beats a same-edge timeout.
          if (nAS) begin
            state_q   <= S_IDLE;
            ioreq_q   <= 1'b0;
            iowrite_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (IOAck) begin
            state_q   <= S_ACK;
            ioreq_q   <= 1'b0;
            iowrite_q <= 1'b0;
          end else if (to_q == 8'(TO_CYC - 1)) begin
            state_q   <= S_ERR;
            ioreq_q   <= 1'b0;
            iowrite_q <= 1'b0;
            to_q      <= 8'(TO_CYC);
          end else begin
            to_q <= to_q + 8'd1;
          end
        end

        S_ACK: begin
          if (nAS) begin
            state_q   <= S_IDLE;
            dtack_n_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            dtack_n_q <= 1'b0;
          end
        end

        S_ERR: begin
          if (nAS) begin
            state_q  <= S_IDLE;
            berr_n_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            berr_n_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Spacing disabled: the counter is held clear, overriding any reload.
      if (!IOSlowEN) gap_q <= 8'd0;
    end
  end

  assign IOReq   = ioreq_q;
  assign IOWrite = iowrite_q;
  assign nDTACK  = dtack_n_q;
  assign nBERR   = berr_n_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_ws_sequencer.sv
// Directed testbench for ws_sequencer (default parameters).
// Outputs are checked as one vector {IOReq, IOWrite, nDTACK, nBERR, Busy},
// sampled 1 time unit after each rising FCLK edge.
module tb_ws_sequencer;

  logic       FCLK = 1'b0;
  logic       RST;
  logic       nAS;
  logic       nWE;
  logic [3:0] A;
  logic       RAMWS;
  logic       ROMWS;
  logic       IOWS;
  logic       IOSlowEN;
  logic       IOAck;
  logic       IOReq;
  logic       IOWrite;
  logic       nDTACK;
  logic       nBERR;
  logic       Busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [4:0] outs;
  assign outs = {IOReq, IOWrite, nDTACK, nBERR, Busy};

  // Expected output vectors {IOReq, IOWrite, nDTACK, nBERR, Busy}
  localparam logic [4:0] V_IDLE  = 5'b00110;
  localparam logic [4:0] V_BUSY  = 5'b00111;
  localparam logic [4:0] V_DTACK = 5'b00011;
  localparam logic [4:0] V_BERR  = 5'b00101;
  localparam logic [4:0] V_REQW  = 5'b11111;
  localparam logic [4:0] V_REQR  = 5'b10111;

  ws_sequencer dut (
    .FCLK    (FCLK),
    .RST     (RST),
    .nAS     (nAS),
    .nWE     (nWE),
    .A       (A),
    .RAMWS   (RAMWS),
    .ROMWS   (ROMWS),
    .IOWS    (IOWS),
    .IOSlowEN(IOSlowEN),
    .IOAck   (IOAck),
    .IOReq   (IOReq),
    .IOWrite (IOWrite),
    .nDTACK  (nDTACK),
    .nBERR   (nBERR),
    .Busy    (Busy)
  );

  always #5 FCLK = ~FCLK;

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    tests_run++;
    assert (outs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b (IOReq,IOWrite,nDTACK,nBERR,Busy)",
             tag, outs, exp);
    end
    $display("[TB] %s: outs=%b", tag, outs);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; nAS = 1'b1; nWE = 1'b1; A = 4'h0;
    RAMWS = 1'b0; ROMWS = 1'b0; IOWS = 1'b0; IOSlowEN = 1'b0; IOAck = 1'b0;
    #1;
    chk("reset", V_IDLE);
    ticks(2);
    RST = 1'b0;
    tick();

    // RAM read, no wait states: nDTACK on edge 2
    A = 4'h0; nAS = 1'b0;
    tick(); chk("ram0_e1", V_BUSY);
    tick(); chk("ram0_e2", V_DTACK);
    nAS = 1'b1;
    tick(); chk("ram0_release", V_IDLE);

    // RAM read, RAMWS=1: nDTACK on edge 3
    RAMWS = 1'b1; nAS = 1'b0;
    tick(); chk("ram1_e1", V_BUSY);
    tick(); chk("ram1_e2", V_BUSY);
    tick(); chk("ram1_e3", V_DTACK);
    nAS = 1'b1; RAMWS = 1'b0;
    tick(); chk("ram1_release", V_IDLE);

    // ROM read, ROMWS=1: nDTACK on edge 4, IOReq never rises
    A = 4'h4; ROMWS = 1'b1; nAS = 1'b0;
    tick(); chk("rom_e1", V_BUSY);
    tick(); chk("rom_e2", V_BUSY);
    tick(); chk("rom_e3", V_BUSY);
    tick(); chk("rom_e4", V_DTACK);
    nAS = 1'b1; ROMWS = 1'b0;
    tick(); chk("rom_release", V_IDLE);

    // I/O write, IOWS=1: IOReq/IOWrite at edge 4, IOAck 5 cycles later
    A = 4'hE; nWE = 1'b0; IOWS = 1'b1; nAS = 1'b0;
    tick(); chk("iow_e1", V_BUSY);
    tick(); chk("iow_e2", V_BUSY);
    tick(); chk("iow_e3", V_BUSY);
    tick(); chk("iow_e4_req", V_REQW);
    ticks(4); chk("iow_e8_req_held", V_REQW);
    IOAck = 1'b1;
    tick(); chk("iow_ack_reqdrop", V_BUSY);
    IOAck = 1'b0;
    tick(); chk("iow_dtack", V_DTACK);
    nAS = 1'b1; IOWS = 1'b0;
    tick(); chk("iow_release", V_IDLE);

    // Write spacing: first write request at edge R, second at R+9
    IOSlowEN = 1'b1; nAS = 1'b0;
    tick(); chk("gap_w1_req", V_REQW);
    IOAck = 1'b1;
    tick(); chk("gap_w1_ack", V_BUSY);
    IOAck = 1'b0;
    tick(); chk("gap_w1_dtack", V_DTACK);
    nAS = 1'b1;
    tick(); chk("gap_w1_release", V_IDLE);
    nAS = 1'b0;
    tick(); chk("gap_w2_held_r4", V_BUSY);
    ticks(4); chk("gap_w2_held_r8", V_BUSY);
    tick(); chk("gap_w2_req_r9", V_REQW);
    IOAck = 1'b1;
    tick(); chk("gap_w2_ack", V_BUSY);
    IOAck = 1'b0;
    tick(); chk("gap_w2_dtack", V_DTACK);
    nAS = 1'b1;
    tick(); chk("gap_w2_release", V_IDLE);

    // I/O read while the gap counter is still running: not delayed
    nWE = 1'b1; nAS = 1'b0;
    tick(); chk("gap_read_nodelay", V_REQR);
    IOAck = 1'b1;
    tick(); chk("gap_read_ack", V_BUSY);
    IOAck = 1'b0;
    tick(); chk("gap_read_dtack", V_DTACK);
    nAS = 1'b1;
    tick(); chk("gap_read_release", V_IDLE);

    // Spacing disabled: back-to-back writes both request immediately
    IOSlowEN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nWE = 1'b0; nAS = 1'b0;
      tick(); chk($sformatf("nogap_w%0d_req", k), V_REQW);
      IOAck = 1'b1;
      tick(); chk($sformatf("nogap_w%0d_ack", k), V_BUSY);
      IOAck = 1'b0;
      tick(); chk($sformatf("nogap_w%0d_dtack", k), V_DTACK);
      nAS = 1'b1;
      tick(); chk($sformatf("nogap_w%0d_release", k), V_IDLE);
    end

    // I/O read timeout: IOReq for 255 cycles, then nBERR
    A = 4'h8; nWE = 1'b1; nAS = 1'b0;
    tick(); chk("to_req", V_REQR);
    ticks(254); chk("to_req_254", V_REQR);
    tick(); chk("to_err_enter", V_BUSY);
    tick(); chk("to_berr", V_BERR);
    tick(); chk("to_berr_held", V_BERR);
    nAS = 1'b1;
    tick(); chk("to_release", V_IDLE);

    // IOAck on the timeout edge: acknowledge wins
    nAS = 1'b0;
    tick(); chk("tie_req", V_REQR);
    ticks(254); chk("tie_req_254", V_REQR);
    IOAck = 1'b1;
    tick(); chk("tie_ack_enter", V_BUSY);
    IOAck = 1'b0;
    tick(); chk("tie_dtack", V_DTACK);
    nAS = 1'b1;
    tick(); chk("tie_release", V_IDLE);

    // Abort during IOREQ, then a late IOAck is ignored
    A = 4'hE; nWE = 1'b0; nAS = 1'b0;
    tick(); chk("abort_req", V_REQW);
    tick(); chk("abort_req_held", V_REQW);
    nAS = 1'b1;
    tick(); chk("abort_drop", V_IDLE);
    IOAck = 1'b1;
    tick(); chk("abort_late_ack1", V_IDLE);
    tick(); chk("abort_late_ack2", V_IDLE);
    IOAck = 1'b0;

    // Reset pulse during a ROM wait: outputs clear without a clock edge
    A = 4'h4; nWE = 1'b1; ROMWS = 1'b1; nAS = 1'b0;
    tick(); chk("rst_wait", V_BUSY);
    #2 RST = 1'b1;
    #1 chk("rst_async", V_IDLE);
    nAS = 1'b1; ROMWS = 1'b0;
    tick();
    RST = 1'b0;
    tick(); chk("rst_after", V_IDLE);

    // Recovery: plain RAM read after reset
    A = 4'h2; nAS = 1'b0;
    tick(); chk("recov_e1", V_BUSY);
    tick(); chk("recov_e2", V_DTACK);
    nAS = 1'b1;
    tick(); chk("recov_release", V_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ws_sequencer.md
Name: ws_sequencer

Overview:
- Front-side-bus access sequencer for the accelerator CPLD.
- Classifies each 68000-style bus cycle as RAM, ROM or I/O from A[23:20].
- Inserts the configured wait states (ROMWS/RAMWS/IOWS), hands I/O cycles to the slow-bus bridge over a req/ack handshake, and terminates every cycle with nDTACK or nBERR.
- Also enforces minimum spacing between I/O writes when slowdown is enabled.

Parameters:
- RAM_WS, 1: wait cycles added to RAM accesses when RAMWS=1.
- ROM_WS, 2: wait cycles added to ROM accesses when ROMWS=1.
- IO_WS, 3: wait cycles before raising IOReq when IOWS=1.
- IO_GAP, 8: minimum FCLK cycles between successive I/O write starts when IOSlowEN=1.
- TO_CYC, 255: IOReq timeout in cycles; 8-bit counter.

Ports:
- FCLK  in  1  fast bus clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- nAS  in  1  address strobe, active low, already synchronous to FCLK.
- nWE  in  1  0 = write cycle.
- A  in  4  A[23:20] of the current cycle.
- RAMWS  in  1  RAM wait-state enable.
- ROMWS  in  1  ROM wait-state enable.
- IOWS  in  1  I/O wait-state enable.
- IOSlowEN  in  1  I/O write spacing enable.
- IOAck  in  1  bridge completion, level, held until IOReq falls.
- IOReq  out  1  request to slow-bus bridge.
- IOWrite  out  1  latched nWE inverse, valid while IOReq=1.
- nDTACK  out  1  data acknowledge, active low.
- nBERR  out  1  bus error, active low.
- Busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE, IOReq=0, IOWrite=0, nDTACK=1, nBERR=1, Busy=0, wait counter=0, gap counter=0, timeout counter=0. All outputs are registered.
- Decode is latched in IDLE on the first edge with nAS=0:
  - RAM: A[23]=0.
  - ROM: A=4'h4.
  - I/O: all other values.
- States: IDLE, WAIT, GAP, IOREQ, ACK, ERR.
- IDLE, nAS=0, class RAM/ROM:
  - Load the counter with RAM_WS/ROM_WS if its enable=1, else 0.
  - Go to WAIT if count>0, else ACK.
- IDLE, nAS=0, class I/O:
  - If it is a write, IOSlowEN=1 and the gap counter ≠ 0, go to GAP.
  - Otherwise load IO_WS (if IOWS=1, else 0) and go to WAIT, or go straight to IOREQ when the load is 0.
- WAIT: decrement each cycle. At the cycle the counter reaches 1, go to ACK (RAM/ROM) or IOREQ (I/O).
- GAP: hold until the gap counter reaches 0, then proceed exactly as the non-gated I/O path.
- IOREQ:
  - IOReq=1. The timeout counter increments each cycle.
  - IOAck=1: IOReq=0 and go to ACK.
  - Counter reaches TO_CYC: IOReq=0 and go to ERR.
- ACK: nDTACK=0 while nAS=0. Stay until nAS=1, then nDTACK=1 and IDLE on the same edge.
- ERR: nBERR=0 until nAS=1, then IDLE.
- Latency, zero wait states: nDTACK falls on the 2nd edge after nAS is sampled low.
  - Edge 1: IDLE→ACK.
  - Edge 2: registered nDTACK=0.
  - Each wait state adds exactly one cycle.
- Gap counter:
  - Loaded with IO_GAP on the edge IOReq rises for a write; decrements to 0 and saturates.
  - While IOSlowEN=0 it is forced to 0.
  - Reads never load it or wait on it.
- Abort: nAS=1 while in WAIT, GAP or IOREQ → IDLE next edge with IOReq=0 and no nDTACK or nBERR pulse.
  - The bridge sees IOReq fall; a late IOAck is ignored.
- IOAck and timeout on the same edge: IOAck wins (ACK, not ERR).
- nDTACK and nBERR are never low simultaneously.
- No new cycle is accepted until nAS has been seen high, so back-to-back cycles need nAS=1 for at least one edge.
- Config inputs (RAMWS, ROMWS, IOWS, IOSlowEN) are sampled only at IDLE decode; changes mid-cycle have no effect on that cycle.
- RST asserted mid-cycle: all outputs return to reset values immediately (asynchronously).

Test Plan:
- RAM read, A=4'h0, RAMWS=0 → nDTACK=0 on edge 2 after nAS low; with RAMWS=1, RAM_WS=1 → edge 3; nDTACK=1 one edge after nAS rises.
- ROM read, A=4'h4, ROMWS=1, ROM_WS=2 → nDTACK on edge 4; IOReq stays 0 throughout.
- I/O write, A=4'hE, IOWS=1, IO_WS=3 → IOReq=1 and IOWrite=1 at edge 4; IOAck after 5 cycles → nDTACK=0 one edge later, IOReq=0.
- Two I/O writes, IOSlowEN=1, IO_GAP=8, second nAS 3 cycles after first IOReq → second IOReq no earlier than 8 cycles after first; repeat with IOSlowEN=0 → no spacing; an I/O read in between is not delayed.
- I/O read, IOAck never asserted → nBERR=0 after 255 IOReq cycles, nDTACK stays 1; IOAck and timeout on the same edge → nDTACK, no nBERR.
- nAS released during IOREQ → IOReq=0 next edge, no acknowledge pulse, late IOAck ignored; RST pulse during WAIT → all outputs at reset values immediately.
